scrambler_par: RTL and testbench

Parallel 802.11a frame scrambler/descrambler: applies the x^7 + x^4 + 1 sequence to DATA_W bits per clock behind a valid/ready handshake, with a per-frame seed load and framing via a last flag. It replaces the serial bit-per-cycle scrambler on the TX path between the PSDU/SERVICE assembler and the convolutional encoder. It is also instantiated on the RX path after the Viterbi decoder as the descrambler, where the optional seed recovery is used.

---
 rtl/scrambler_par.sv | 213 +++++++++++++++++++++
 tb/tb_scrambler_par.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scrambler_par.sv
// scrambler_par - parallel 802.11a scrambler / descrambler, x^7 + x^4 + 1.
//
// DATA_W bits are processed per beat behind valid/ready handshakes, with
// in_data[0] as the first bit on air. The LFSR walk is unrolled, so the
// period stays 127 bits whatever the beat width. A frame starts with a load
// pulse that seeds the LFSR from init_state. The final beat is flagged with
// in_last, and that flag travels with the data to out_last.
//
// Build option: define SCRAMBLER_SEED_RECOVERY_EN to add the recover port and
// a 3-bit recovery counter. The RX descrambler uses them to rebuild the
// transmitter's LFSR state from the seven leading SERVICE bits, whose
// plaintext is always zero.
module scrambler_par #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [6:0]        init_state,
   input  logic              load,
`ifdef SCRAMBLER_SEED_RECOVERY_EN
   input  logic              recover,
`endif
   input  logic              in_valid,
   output logic              in_rdy,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_rdy,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              seed_err
);

   localparam logic [6:0] SEED_ALL_ONES = 7'h7F;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [6:0]          lfsr_q, lfsr_d;
   logic                out_valid_q, out_valid_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic                out_last_q, out_last_d;
   logic                seed_err_q, seed_err_d;
`ifdef SCRAMBLER_SEED_RECOVERY_EN
   logic [2:0]          rc_q, rc_d;
   logic [2:0]          rc_start_s, rc_walk_s;
`endif

   logic                run_s;
   logic                in_rdy_s;
   logic                accept_s;
   logic                recover_s;
   logic                bad_seed_s;
   logic [6:0]          seed_s;
   logic [6:0]          lfsr_start_s;
   logic [6:0]          lfsr_walk_s;
   logic [DATA_W-1:0]   scr_data_s;
   logic                fb_s;

   // Seed selection: an all-zero seed would lock the LFSR, so all-ones is
   // used in its place and the event is flagged. Recovery starts from zero
   // because the state is rebuilt from received bits.
   always_comb begin
`ifdef SCRAMBLER_SEED_RECOVERY_EN
      recover_s = recover;
`else
      recover_s = 1'b0;
`endif
      if (recover_s) begin
         seed_s     = 7'h00;
         bad_seed_s = 1'b0;
      end else if (init_state == 7'h00) begin
         seed_s     = SEED_ALL_ONES;
         bad_seed_s = 1'b1;
      end else begin
         seed_s     = init_state;
         bad_seed_s = 1'b0;
      end
      if (load) begin
         lfsr_start_s = seed_s;
      end else begin
         lfsr_start_s = lfsr_q;
      end
   end

`ifdef SCRAMBLER_SEED_RECOVERY_EN
   // Recovery counter start value: a load restarts it, or clears it when recovery is not requested
   always_comb begin
      if (load) begin
         rc_start_s = recover ? 3'd7 : 3'd0;
      end else begin
         rc_start_s = rc_q;
      end
   end
`endif

   // Walk the LFSR across the beat one bit at a time in air order, starting
   // from the fresh seed when load coincides with the beat
   always_comb begin
      lfsr_walk_s = lfsr_start_s;
      scr_data_s  = '0;
      fb_s        = 1'b0;
`ifdef SCRAMBLER_SEED_RECOVERY_EN
      rc_walk_s   = rc_start_s;
`endif
      for (int i = 0; i < DATA_W; i++) begin
`ifdef SCRAMBLER_SEED_RECOVERY_EN
         if (rc_walk_s != 3'd0) begin
            // SERVICE bit: plaintext is zero, so the received bit is the keystream bit
            fb_s          = in_data[i];
            scr_data_s[i] = 1'b0;
            rc_walk_s     = rc_walk_s - 3'd1;
         end else begin
            fb_s          = lfsr_walk_s[6] ^ lfsr_walk_s[3];
            scr_data_s[i] = in_data[i] ^ fb_s;
         end
`else
         fb_s          = lfsr_walk_s[6] ^ lfsr_walk_s[3];
         scr_data_s[i] = in_data[i] ^ fb_s;
`endif
         lfsr_walk_s = {lfsr_walk_s[5:0], fb_s};
      end
   end

   // Handshake and frame state: a load in IDLE opens the input in the same
   // cycle, so a frame whose first beat arrives with load has no bubble
   always_comb begin
      case (state_q)
         ST_IDLE: run_s = load;
         ST_RUN:  run_s = 1'b1;
         default: run_s = 1'b0;
      endcase
      in_rdy_s = !reset && run_s && (!out_valid_q || out_rdy);
      accept_s = in_valid && in_rdy_s;
      if (accept_s && in_last) begin
         state_d = ST_IDLE;
      end else if (load) begin
         state_d = ST_RUN;
      end else begin
         state_d = state_q;
      end
   end

   // Next LFSR, output register and sticky error values
   always_comb begin
      if (accept_s) begin
         lfsr_d = lfsr_walk_s;
      end else begin
         lfsr_d = lfsr_start_s;
      end
      if (accept_s) begin
         out_valid_d = 1'b1;
         out_data_d  = scr_data_s;
         out_last_d  = in_last;
      end else if (out_rdy) begin
         out_valid_d = 1'b0;
         out_data_d  = out_data_q;
         out_last_d  = out_last_q;
      end else begin
         out_valid_d = out_valid_q;
         out_data_d  = out_data_q;
         out_last_d  = out_last_q;
      end
      seed_err_d = seed_err_q | (load & bad_seed_s);
`ifdef SCRAMBLER_SEED_RECOVERY_EN
      if (accept_s) begin
         rc_d = rc_walk_s;
      end else begin
         rc_d = rc_start_s;
      end
`endif
   end

   // State, LFSR and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         lfsr_q      <= SEED_ALL_ONES;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         seed_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         seed_err_q  <= seed_err_d;
      end
   end

`ifdef SCRAMBLER_SEED_RECOVERY_EN
   // Recovery counter register
   always_ff @(posedge clk) begin
      if (reset) begin
         rc_q <= 3'd0;
      end else begin
         rc_q <= rc_d;
      end
   end
`endif

   assign in_rdy    = in_rdy_s;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign seed_err  = seed_err_q;

endmodule

// File: tb/tb_scrambler_par.sv
// tb_scrambler_par - self-checking bench for scrambler_par (DATA_W = 8).
// The reference keystream is the recurrence x[n] = x[n-7] ^ x[n-4], seeded
// with the seven bits x[-7..-1] = init_state[6..0].
`timescale 1ns/1ps
module tb_scrambler_par;
   localparam int W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset = 1'b1;
   logic         load = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_last = 1'b0;
   logic [6:0]   init_state = 7'h00;
   logic [W-1:0] in_data = '0;
   logic         tb_out_rdy = 1'b1;
   logic         rdy_rand = 1'b0;
   logic         rdy_fix = 1'b1;
   logic         chain = 1'b0;
   logic         recover = 1'b0;

   logic         in_rdy, out_valid, out_last, seed_err, dut_out_rdy;
   logic [W-1:0] out_data;
   logic         rx_load, rx_in_rdy, rx_out_valid, rx_out_last, rx_seed_err;
   logic [W-1:0] rx_out_data;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   typedef struct {
      logic         last;
      logic [W-1:0] data;
      int           t;
   } beat_t;
   beat_t got_q[$];
   beat_t rx_q[$];
   logic  ks[$];

   assign dut_out_rdy = chain ? rx_in_rdy : tb_out_rdy;
   assign rx_load     = chain & load;

   scrambler_par #(.DATA_W(W)) u_dut (
      .clk(clk), .reset(reset), .init_state(init_state), .load(load),
`ifdef SCRAMBLER_SEED_RECOVERY_EN
      .recover(recover),
`endif
      .in_valid(in_valid), .in_rdy(in_rdy), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_rdy(dut_out_rdy), .out_data(out_data),
      .out_last(out_last), .seed_err(seed_err)
   );

   scrambler_par #(.DATA_W(W)) u_rx (
      .clk(clk), .reset(reset), .init_state(init_state), .load(rx_load),
`ifdef SCRAMBLER_SEED_RECOVERY_EN
      .recover(recover),
`endif
      .in_valid(out_valid), .in_rdy(rx_in_rdy), .in_data(out_data), .in_last(out_last),
      .out_valid(rx_out_valid), .out_rdy(tb_out_rdy), .out_data(rx_out_data),
      .out_last(rx_out_last), .seed_err(rx_seed_err)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Output collectors: record every completed output transfer
   always @(negedge clk) begin
      if (!reset && out_valid && dut_out_rdy) got_q.push_back('{out_last, out_data, cyc});
      if (!reset && rx_out_valid && tb_out_rdy) rx_q.push_back('{rx_out_last, rx_out_data, cyc});
   end

   // out_rdy driver: fixed level or random per cycle
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (rdy_rand) tb_out_rdy = ($urandom_range(0, 1) != 0);
         else tb_out_rdy = rdy_fix;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, summary not printed");
      $fatal(1, "watchdog");
   end

   function automatic void ks_seed(input logic [6:0] s);
      logic [6:0] e;
      e = (s == 7'h00) ? 7'h7F : s;
      ks.delete();
      for (int k = 6; k >= 0; k--) ks.push_back(e[k]);
   endfunction

   function automatic logic [W-1:0] ks_apply(input logic [W-1:0] d);
      logic [W-1:0] r;
      logic b;
      r = '0;
      for (int i = 0; i < W; i++) begin
         b = ks[0] ^ ks[3];
         void'(ks.pop_front());
         ks.push_back(b);
         r[i] = d[i] ^ b;
      end
      return r;
   endfunction

   // Present one beat (optionally with load) and hold it until accepted
   task automatic send(input logic [W-1:0] d, input logic l, input logic ld, input logic [6:0] seed);
      int t;
      t = 0;
      in_data = d; in_last = l; in_valid = 1'b1; load = ld; init_state = seed;
      @(negedge clk);
      while (!in_rdy && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!in_rdy) begin
         n_cmp++; n_err++;
         $display("FAIL accept_timeout: in_rdy=%b after %0d cycles, required 1", in_rdy, t);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; load = 1'b0; in_last = 1'b0;
   endtask

   task automatic wait_out(input int n);
      int t;
      t = 0;
      while (got_q.size() < n && t < 2000) begin
         @(posedge clk); #1;
         t++;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %h want 00", out_data); end
      n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last: got %b want 0", out_last); end
      n_cmp++; if (seed_err !== 1'b0) begin n_err++; $display("FAIL reset_seed_err: got %b want 0", seed_err); end
      n_cmp++; if (in_rdy !== 1'b0) begin n_err++; $display("FAIL reset_in_rdy: got %b want 0", in_rdy); end
   endtask

   task automatic test_known_vector();
      got_q.delete();
      send(8'h00, 1'b0, 1'b1, 7'h7F);
      send(8'h00, 1'b1, 1'b0, 7'h7F);
      wait_out(2);
      n_cmp++; if (got_q.size() != 2) begin n_err++; $display("FAIL kv_count: got %0d want 2", got_q.size()); end
      if (got_q.size() >= 2) begin
         n_cmp++; if (got_q[0].data !== 8'h70) begin n_err++; $display("FAIL kv_beat0: got %h want 70", got_q[0].data); end
         n_cmp++; if (got_q[1].data !== 8'h4F) begin n_err++; $display("FAIL kv_beat1: got %h want 4f", got_q[1].data); end
         n_cmp++; if (got_q[0].last !== 1'b0 || got_q[1].last !== 1'b1) begin
            n_err++; $display("FAIL kv_last: got %b%b want 01", got_q[0].last, got_q[1].last);
         end
      end
   endtask

   task automatic test_period();
      logic [W-1:0] e[$];
      got_q.delete();
      ks_seed(7'h7F);
      for (int k = 0; k < 128; k++) begin
         e.push_back(ks_apply(8'h00));
         send(8'h00, (k == 127), (k == 0), 7'h7F);
      end
      wait_out(128);
      n_cmp++; if (got_q.size() != 128) begin n_err++; $display("FAIL period_count: got %0d want 128", got_q.size()); end
      if (got_q.size() == 128) begin
         n_cmp++; if (got_q[127].data !== 8'h70) begin n_err++; $display("FAIL period_beat128: got %h want 70", got_q[127].data); end
         for (int k = 0; k < 128; k++) begin
            n_cmp++; if (got_q[k].data !== e[k]) begin n_err++; $display("FAIL period_data[%0d]: got %h want %h", k, got_q[k].data, e[k]); end
            n_cmp++; if (got_q[k].last !== (k == 127)) begin n_err++; $display("FAIL period_last[%0d]: got %b want %b", k, got_q[k].last, (k == 127)); end
            if (k > 0) begin
               n_cmp++; if (got_q[k].t != got_q[k-1].t + 1) begin n_err++; $display("FAIL period_gap[%0d]: got spacing %0d want 1", k, got_q[k].t - got_q[k-1].t); end
            end
         end
      end
   endtask

   task automatic test_round_trip();
      logic [W-1:0] d, p[$], e[$];
      localparam int N = 24;
      got_q.delete(); rx_q.delete();
      chain = 1'b1; rdy_rand = 1'b1;
      ks_seed(7'h43);
      for (int k = 0; k < N; k++) begin
         d = W'($urandom);
         p.push_back(d);
         e.push_back(ks_apply(d));
         send(d, (k == N-1), (k == 0), 7'h43);
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      for (int t = 0; t < 2000 && rx_q.size() < N; t++) begin @(posedge clk); #1; end
      n_cmp++; if (rx_q.size() != N) begin n_err++; $display("FAIL rt_rx_count: got %0d want %0d", rx_q.size(), N); end
      n_cmp++; if (got_q.size() != N) begin n_err++; $display("FAIL rt_tx_count: got %0d want %0d", got_q.size(), N); end
      for (int k = 0; k < N && k < rx_q.size() && k < got_q.size(); k++) begin
         n_cmp++; if (got_q[k].data !== e[k]) begin n_err++; $display("FAIL rt_tx_data[%0d]: got %h want %h", k, got_q[k].data, e[k]); end
         n_cmp++; if (rx_q[k].data !== p[k]) begin n_err++; $display("FAIL rt_rx_data[%0d]: got %h want %h", k, rx_q[k].data, p[k]); end
         n_cmp++; if (rx_q[k].last !== (k == N-1)) begin n_err++; $display("FAIL rt_rx_last[%0d]: got %b want %b", k, rx_q[k].last, (k == N-1)); end
      end
      n_cmp++; if (rx_seed_err !== 1'b0) begin n_err++; $display("FAIL rt_rx_seed_err: got %b want 0", rx_seed_err); end
      chain = 1'b0; rdy_rand = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
   endtask

   task automatic test_seed_zero();
      logic [W-1:0] d, e[$];
      got_q.delete();
      ks_seed(7'h7F);
      for (int k = 0; k < 3; k++) begin
         d = (k == 0) ? 8'h00 : W'($urandom);
         e.push_back(ks_apply(d));
         send(d, (k == 2), (k == 0), 7'h00);
      end
      wait_out(3);
      n_cmp++; if (seed_err !== 1'b1) begin n_err++; $display("FAIL sz_seed_err_set: got %b want 1", seed_err); end
      ks_seed(7'h25);
      for (int k = 0; k < 2; k++) begin
         d = W'($urandom);
         e.push_back(ks_apply(d));
         send(d, (k == 1), (k == 0), 7'h25);
      end
      wait_out(5);
      n_cmp++; if (got_q.size() != 5) begin n_err++; $display("FAIL sz_count: got %0d want 5", got_q.size()); end
      if (got_q.size() >= 1) begin
         n_cmp++; if (got_q[0].data !== 8'h70) begin n_err++; $display("FAIL sz_first: got %h want 70", got_q[0].data); end
      end
      for (int k = 0; k < 5 && k < got_q.size(); k++) begin
         n_cmp++; if (got_q[k].data !== e[k]) begin n_err++; $display("FAIL sz_data[%0d]: got %h want %h", k, got_q[k].data, e[k]); end
      end
      n_cmp++; if (seed_err !== 1'b1) begin n_err++; $display("FAIL sz_seed_err_sticky: got %b want 1", seed_err); end
      do_reset();
      n_cmp++; if (seed_err !== 1'b0) begin n_err++; $display("FAIL sz_seed_err_cleared: got %b want 0", seed_err); end
   endtask

   task automatic test_reload();
      logic [W-1:0] d, e[$];
      logic         el[$];
      got_q.delete();
      ks_seed(7'h7F);
      d = W'($urandom); e.push_back(ks_apply(d)); el.push_back(1'b0); send(d, 1'b0, 1'b1, 7'h7F);
      d = W'($urandom); e.push_back(ks_apply(d)); el.push_back(1'b0); send(d, 1'b0, 1'b0, 7'h7F);
      ks_seed(7'h11);
      d = W'($urandom); e.push_back(ks_apply(d)); el.push_back(1'b0); send(d, 1'b0, 1'b1, 7'h11);
      // Load-only cycle while the previous output is stalled
      rdy_fix = 1'b0;
      load = 1'b1; init_state = 7'h33;
      @(posedge clk); #1;
      load = 1'b0;
      rdy_fix = 1'b1;
      ks_seed(7'h33);
      d = W'($urandom); e.push_back(ks_apply(d)); el.push_back(1'b0); send(d, 1'b0, 1'b0, 7'h33);
      d = W'($urandom); e.push_back(ks_apply(d)); el.push_back(1'b1); send(d, 1'b1, 1'b0, 7'h33);
      wait_out(5);
      @(posedge clk); #1;
      n_cmp++; if (in_rdy !== 1'b0) begin n_err++; $display("FAIL rl_idle_in_rdy: got %b want 0", in_rdy); end
      ks_seed(7'h5A);
      d = W'($urandom); e.push_back(ks_apply(d)); el.push_back(1'b1); send(d, 1'b1, 1'b1, 7'h5A);
      wait_out(6);
      @(posedge clk); #1;
      n_cmp++; if (in_rdy !== 1'b0) begin n_err++; $display("FAIL rl_single_beat_idle: got %b want 0", in_rdy); end
      n_cmp++; if (got_q.size() != 6) begin n_err++; $display("FAIL rl_count: got %0d want 6", got_q.size()); end
      for (int k = 0; k < 6 && k < got_q.size(); k++) begin
         n_cmp++; if (got_q[k].data !== e[k]) begin n_err++; $display("FAIL rl_data[%0d]: got %h want %h", k, got_q[k].data, e[k]); end
         n_cmp++; if (got_q[k].last !== el[k]) begin n_err++; $display("FAIL rl_last[%0d]: got %b want %b", k, got_q[k].last, el[k]); end
      end
   endtask

   task automatic test_reset_midframe();
      got_q.delete();
      rdy_fix = 1'b0;
      @(posedge clk); #1;
      send(8'hA5, 1'b0, 1'b1, 7'h7F);
      in_valid = 1'b1; in_data = 8'h3C;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rm_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (in_rdy !== 1'b0) begin n_err++; $display("FAIL rm_in_rdy: got %b want 0", in_rdy); end
      n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL rm_out_data: got %h want 00", out_data); end
      rdy_fix = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      n_cmp++; if (got_q.size() != 0) begin n_err++; $display("FAIL rm_dropped: got %0d beats want 0", got_q.size()); end
   endtask

`ifdef SCRAMBLER_SEED_RECOVERY_EN
   logic       t4_load = 1'b0, t4_valid = 1'b0, t4_last = 1'b0;
   logic [3:0] t4_data = 4'h0;
   logic       t4_in_rdy, t4_out_valid, t4_out_last, t4_seed_err;
   logic [3:0] t4_out_data, r4_out_data;
   logic       r4_in_rdy, r4_out_valid, r4_out_last, r4_seed_err;
   logic [3:0] r4_q[$];

   scrambler_par #(.DATA_W(4)) u_tx4 (
      .clk(clk), .reset(reset), .init_state(7'h5D), .load(t4_load), .recover(1'b0),
      .in_valid(t4_valid), .in_rdy(t4_in_rdy), .in_data(t4_data), .in_last(t4_last),
      .out_valid(t4_out_valid), .out_rdy(r4_in_rdy), .out_data(t4_out_data),
      .out_last(t4_out_last), .seed_err(t4_seed_err)
   );
   scrambler_par #(.DATA_W(4)) u_rx4 (
      .clk(clk), .reset(reset), .init_state(7'h00), .load(t4_load), .recover(1'b1),
      .in_valid(t4_out_valid), .in_rdy(r4_in_rdy), .in_data(t4_out_data), .in_last(t4_out_last),
      .out_valid(r4_out_valid), .out_rdy(1'b1), .out_data(r4_out_data),
      .out_last(r4_out_last), .seed_err(r4_seed_err)
   );

   always @(negedge clk) if (!reset && r4_out_valid) r4_q.push_back(r4_out_data);

   task automatic test_recover();
      logic [3:0] pt[$];
      int t;
      r4_q.delete();
      for (int k = 0; k < 10; k++) pt.push_back((k < 4) ? 4'h0 : 4'($urandom));
      for (int k = 0; k < 10; k++) begin
         t4_data = pt[k]; t4_last = (k == 9); t4_valid = 1'b1; t4_load = (k == 0);
         t = 0;
         @(negedge clk);
         while (!t4_in_rdy && t < 100) begin @(negedge clk); t++; end
         @(posedge clk); #1;
         t4_valid = 1'b0; t4_load = 1'b0; t4_last = 1'b0;
      end
      for (int w = 0; w < 100 && r4_q.size() < 10; w++) begin @(posedge clk); #1; end
      n_cmp++; if (r4_q.size() != 10) begin n_err++; $display("FAIL rec_count: got %0d want 10", r4_q.size()); end
      for (int k = 0; k < 10 && k < r4_q.size(); k++) begin
         n_cmp++; if (r4_q[k] !== pt[k]) begin n_err++; $display("FAIL rec_data[%0d]: got %h want %h", k, r4_q[k], pt[k]); end
      end
      n_cmp++; if (r4_seed_err !== 1'b0) begin n_err++; $display("FAIL rec_seed_err: got %b want 0", r4_seed_err); end
      n_cmp++; if (t4_seed_err !== 1'b0 || r4_out_last !== 1'b1) begin
         n_err++; $display("FAIL rec_tail: seed_err %b last %b want 0 1", t4_seed_err, r4_out_last);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_known_vector();
      test_period();
      test_round_trip();
      test_seed_zero();
      test_reload();
      test_reset_midframe();
`ifdef SCRAMBLER_SEED_RECOVERY_EN
      test_recover();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
